// File: rtl/systolic_tile_feeder.sv
// rtl/systolic_tile_feeder.sv - sequences A/B tile pairs into the 2x2 systolic array, one pair per inner-dimension step
module systolic_tile_feeder #(
    parameter int WIDTH           = 16,
    parameter int FRAC_WIDTH      = 8,
    parameter int BLOCK_SIZE      = 2,
    parameter int CHUNK_SIZE      = 4,
    parameter int INNER_DIMENSION = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH*CHUNK_SIZE-1:0]   a_in,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [WIDTH*CHUNK_SIZE-1:0]   b_in,
    input  logic                          b_valid,
    output logic                          b_ready,
    output logic [WIDTH*CHUNK_SIZE-1:0]   sys_a,
    output logic [WIDTH*CHUNK_SIZE-1:0]   sys_b,
    output logic                          sys_start,
    output logic                          sys_first,
    output logic                          sys_last,
    input  logic                          systolic_done,
    output logic                          busy,
    output logic                          block_done
);

    localparam int K_TILES = INNER_DIMENSION / BLOCK_SIZE;
    localparam int CNT_W   = (K_TILES > 1) ? $clog2(K_TILES) : 1;
    localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(K_TILES - 1);

    // Elements are opaque fixed-point words; the only use of FRAC_WIDTH is a sanity bound.
    generate
        if ((INNER_DIMENSION % BLOCK_SIZE) != 0 || INNER_DIMENSION < BLOCK_SIZE) begin : g_bad_inner
            $error("INNER_DIMENSION must be a non-zero multiple of BLOCK_SIZE");
        end
        if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE || FRAC_WIDTH > WIDTH) begin : g_bad_tile
            $error("tile geometry or fixed-point format inconsistent");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] tile_cnt;
    logic             a_held;
    logic             b_held;
    logic             a_fire;
    logic             b_fire;
    logic             cnt_is_last;

    assign a_fire      = a_valid && a_ready;
    assign b_fire      = b_valid && b_ready;
    assign cnt_is_last = (tile_cnt == LAST_TILE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        sys_start  = 1'b0;
        sys_first  = 1'b0;
        sys_last   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                a_ready = ~a_held;
                b_ready = ~b_held;
                // A side and B side may complete in either order or together.
                if ((a_held || (a_valid && ~a_held)) && (b_held || (b_valid && ~b_held))) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                sys_start  = 1'b1;
                sys_first  = (tile_cnt == '0);
                sys_last   = cnt_is_last;
                next_state = WAIT;
            end
            WAIT: begin
                if (systolic_done) begin
                    next_state = cnt_is_last ? IDLE : FETCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tile_cnt   <= '0;
            a_held     <= 1'b0;
            b_held     <= 1'b0;
            sys_a      <= '0;
            sys_b      <= '0;
            block_done <= 1'b0;
        end else begin
            block_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tile_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (a_fire) begin
                        sys_a  <= a_in;
                        a_held <= 1'b1;
                    end
                    if (b_fire) begin
                        sys_b  <= b_in;
                        b_held <= 1'b1;
                    end
                end
                ISSUE: begin
                    a_held <= 1'b0;
                    b_held <= 1'b0;
                end
                WAIT: begin
                    if (systolic_done) begin
                        if (cnt_is_last) begin
                            tile_cnt   <= '0;
                            block_done <= 1'b1;
                        end else begin
                            tile_cnt <= tile_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// tb/tb_systolic_tile_feeder.sv - directed self-checking bench for systolic_tile_feeder with K_TILES=4
module tb_systolic_tile_feeder;

    localparam int W  = 16;
    localparam int CS = 4;
    localparam int TW = W * CS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [TW-1:0] a_in;
    logic          a_valid;
    logic          a_ready;
    logic [TW-1:0] b_in;
    logic          b_valid;
    logic          b_ready;
    logic [TW-1:0] sys_a;
    logic [TW-1:0] sys_b;
    logic          sys_start;
    logic          sys_first;
    logic          sys_last;
    logic          systolic_done;
    logic          busy;
    logic          block_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    systolic_tile_feeder #(
        .WIDTH(16), .FRAC_WIDTH(8), .BLOCK_SIZE(2), .CHUNK_SIZE(4), .INNER_DIMENSION(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_in(a_in), .a_valid(a_valid), .a_ready(a_ready),
        .b_in(b_in), .b_valid(b_valid), .b_ready(b_ready),
        .sys_a(sys_a), .sys_b(sys_b),
        .sys_start(sys_start), .sys_first(sys_first), .sys_last(sys_last),
        .systolic_done(systolic_done), .busy(busy), .block_done(block_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [TW-1:0] tile(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    // Present a pair with both valids high and wait for the issue cycle.
    task automatic issue_tile(input int t, input logic [TW-1:0] at, input logic [TW-1:0] bt);
        int n;
        a_in    = at;
        b_in    = bt;
        a_valid = 1'b1;
        b_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!sys_start && n < 10);
        check($sformatf("issue_seen_t%0d", t), sys_start, 1'b1);
        check($sformatf("first_t%0d", t), sys_first, (t == 0));
        check($sformatf("last_t%0d", t), sys_last, (t == 3));
        check($sformatf("sys_a_t%0d", t), sys_a, at);
        check($sformatf("sys_b_t%0d", t), sys_b, bt);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Array answers two cycles after sys_start.
    task automatic finish_tile(input int t, input bit last);
        tick();
        tick();
        systolic_done = 1'b1;
        tick();
        systolic_done = 1'b0;
        check($sformatf("block_done_t%0d", t), block_done, last);
        check($sformatf("busy_after_t%0d", t), busy, !last);
    endtask

    task automatic run_block(input logic [15:0] base);
        for (int t = 0; t < 4; t++) begin
            issue_tile(t, tile(base + 16'(t)), tile(16'h0100 + base + 16'(t)));
            finish_tile(t, t == 3);
        end
    endtask

    task automatic kick;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a_in = '0; a_valid = 1'b0;
        b_in = '0; b_valid = 1'b0; systolic_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_sys_start", sys_start, 1'b0);
        check("rst_ready", {a_ready, b_ready}, 2'b00);
        check("rst_sys_a", sys_a, 64'd0);
        check("rst_block_done", block_done, 1'b0);

        // Basic block with tiles 1..4.
        kick();
        run_block(16'h0001);
        tick();
        check("block_done_single", block_done, 1'b0);
        check("sys_a_kept_idle", sys_a, tile(16'h0004));

        // Stray done in IDLE.
        systolic_done = 1'b1;
        tick();
        systolic_done = 1'b0;
        check("idle_done_busy", busy, 1'b0);
        check("idle_done_bd", block_done, 1'b0);

        // Staggered handshake on tile 0; stray done in FETCH first.
        kick();
        systolic_done = 1'b1;
        tick();
        systolic_done = 1'b0;
        check("fetch_done_ready", {a_ready, b_ready}, 2'b11);
        a_in = tile(16'h00a0);
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stag_a_ready", a_ready, 1'b0);
            check("stag_b_ready", b_ready, 1'b1);
            check("stag_no_start", sys_start, 1'b0);
            if (i == 0) a_in = tile(16'h00ee);
        end
        b_in = tile(16'h00b0);
        b_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("stag_start", sys_start, 1'b1);
        check("stag_first", sys_first, 1'b1);
        check("stag_sys_a", sys_a, tile(16'h00a0));
        check("stag_sys_b", sys_b, tile(16'h00b0));

        // Done in the ISSUE cycle is ignored; WAIT then holds with toggling a_in and a stray start.
        systolic_done = 1'b1;
        tick();
        systolic_done = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_in = tile(16'(i * 7 + 3));
            start = (i == 10);
            tick();
            check("hold_a_ready", a_ready, 1'b0);
            check("hold_busy", busy, 1'b1);
            check("hold_sys_a", sys_a, tile(16'h00a0));
            check("hold_sys_b", sys_b, tile(16'h00b0));
        end
        start = 1'b0;
        a_valid = 1'b0;
        systolic_done = 1'b1;
        tick();
        systolic_done = 1'b0;
        check("stag_t0_done_bd", block_done, 1'b0);
        for (int t = 1; t < 4; t++) begin
            issue_tile(t, tile(16'h0020 + 16'(t)), tile(16'h0030 + 16'(t)));
            finish_tile(t, t == 3);
        end

        // Reset during WAIT of tile 2.
        tick();
        kick();
        for (int t = 0; t < 2; t++) begin
            issue_tile(t, tile(16'h0040 + 16'(t)), tile(16'h0050 + 16'(t)));
            finish_tile(t, 1'b0);
        end
        issue_tile(2, tile(16'h0042), tile(16'h0052));
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_outs", {busy, sys_start, sys_first, sys_last, a_ready, b_ready, block_done}, 7'd0);
        check("mid_rst_sys_a", sys_a, 64'd0);
        check("mid_rst_sys_b", sys_b, 64'd0);
        systolic_done = 1'b1;
        tick();
        systolic_done = 1'b0;
        check("mid_rst_no_bd", block_done, 1'b0);
        kick();
        run_block(16'h0061);

        // Back-to-back: start while block_done is high.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_bd_cleared", block_done, 1'b0);
        run_block(16'h0071);
        tick();
        check("b2b_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
